mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single synchronous-read RAM port (program, font and framebuffer at 0x100) between three requesters: port 0 = display scanout, port 1 = CPU, port 2 = GPU.
- Requesters use the same read/write/ack handshake the GPU already uses. The RAM sees at most one access per cycle.
- Back-to-back accesses are supported at one per cycle.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p0_read, p1_read, p2_read  in  1 each  read request, held until ack
- p0_write, p1_write, p2_write  in  1 each  write request, held until ack
- p0_idx, p1_idx, p2_idx  in  ADDR_W each  address
- p0_wdata, p1_wdata, p2_wdata  in  DATA_W each  write data
- p0_ack, p1_ack, p2_ack  out  1 each  one-cycle completion pulse
- rdata  out  DATA_W  read data broadcast to all ports; valid only for the acked port in its ack cycle
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, registered inside RAM, valid 1 cycle after ram_en
- grant_port  out  2  port issued this cycle (0-2); 3 = none

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all pN_ack = 0; ram_en = ram_we = 0; ram_addr = ram_wdata = 0; grant_port = 3; rr_last = 2, so port 0 wins the first tie; in-flight record cleared.
- Eligibility: port N is eligible when (pN_read | pN_write) & !pN_ack. A port being acked this cycle cannot be re-granted in that same cycle, which matches requesters that drop their request combinationally on ack.
- Issue cycle (combinational from the registered state):
  - Pick one eligible port per the arbitration rule.
  - Drive ram_en = 1, ram_addr = pN_idx.
  - ram_we = pN_write; ram_wdata = pN_wdata on writes, 0 on reads.
  - grant_port = N.
- Completion:
  - pN_ack = 1 exactly one cycle after the issue cycle (registered).
  - For reads, rdata = ram_rdata in that ack cycle.
  - Latency is 1 cycle from grant to ack for both reads and writes.
  - With no eligible port, ram_en = 0 and grant_port = 3.
- Arbitration (default): round-robin over ports 0..2. The search starts at rr_last+1 mod 3. rr_last updates to N on each grant.
- Read and write asserted together by one port: the write is performed, the read is ignored, and a single ack is issued.
- Throughput: a sequence of grants such as p1, p2, p1, p2 with continuous demand yields one access per cycle. No idle cycle is inserted between different ports.
- Starvation bound (default mode): any continuously requesting port is granted within 3 cycles.
- Reset mid-access: the pending ack is dropped; the requester keeps holding its request and is re-arbitrated after reset.
- State is not a multi-state FSM: only the in-flight record (valid, port) plus rr_last.
- Address and data are passed unchanged; no width arithmetic beyond the mod-3 pointer increment.

Optional Feature:
- Macro: MEM_ARB_DISPLAY_PRIO_EN
- Defined: port 0 (display) has strict fixed priority whenever it is eligible. Ports 1 and 2 round-robin among themselves, with rr_last tracking only those two. Display latency is guaranteed at 1 cycle, provided it is not in its own ack cycle.
- Undefined: plain 3-way round-robin as above.

Decomposition:
- Shared package mem_arb_pkg:
  - PORT_DISPLAY = 0, PORT_CPU = 1, PORT_GPU = 2, PORT_NONE = 3.
  - ADDR_W and DATA_W defaults.
  - FRAMEBUF_BASE = 12'h100.
- One natural sub-module: rr_pick3. It is combinational: 3-bit eligible vector plus 2-bit last pointer in, 2-bit winner out, 3 = none. It is instantiated once, or twice under MEM_ARB_DISPLAY_PRIO_EN (once with port 0 masked).

Test Plan:
- Single read: preload RAM[0x200] = 0xA5; p1_read, p1_idx = 0x200 -> issue cycle with ram_en = 1, ram_we = 0, ram_addr = 0x200; next cycle p1_ack = 1 and rdata = 0xA5; no other ack.
- Write then readback: p2_write to idx 0x108 with wdata 0x3C, ack after 1 cycle; then p2_read of 0x108 -> rdata = 0x3C.
- Three-way contention after reset, all ports reading continuously -> grant order 0, 1, 2, 0, 1, 2…; one ram_en per cycle; each port's gap between grants ≤ 3 cycles.
- GPU-style back-to-back: p2 drops read on ack and re-asserts the next cycle with a new address, while p1 requests constantly -> alternating grants; p2 is never granted in its own ack cycle.
- Read+write together: p1_read = p1_write = 1, idx 0x150, wdata 0x77 -> ram_we = 1, exactly one p1_ack, and RAM[0x150] = 0x77.
- Reset mid-access: assert reset in the ack cycle of a p0 read -> p0_ack = 0 that cycle; after reset, p0 is granted first.
- With MEM_ARB_DISPLAY_PRIO_EN: p0 requests every other cycle while p1/p2 saturate -> p0 is granted in every cycle it is eligible.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants, types and helpers for the three-port RAM arbiter.
// Optional build macro MEM_ARB_DISPLAY_PRIO_EN is consumed by mem_arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 8;

    localparam logic [1:0] PORT_DISPLAY = 2'd0;
    localparam logic [1:0] PORT_CPU     = 2'd1;
    localparam logic [1:0] PORT_GPU     = 2'd2;
    localparam logic [1:0] PORT_NONE    = 2'd3;

    localparam logic [11:0] FRAMEBUF_BASE = 12'h100;

    typedef struct packed {
        logic       valid;
        logic [1:0] port;
    } inflight_t;

    // Mod-3 increment; an out-of-range pointer restarts the search at port 0.
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle: read/write/ack handshake for the three ports
// plus the shared read-data broadcast.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);

    logic              p0_read,  p1_read,  p2_read;
    logic              p0_write, p1_write, p2_write;
    logic [ADDR_W-1:0] p0_idx,   p1_idx,   p2_idx;
    logic [DATA_W-1:0] p0_wdata, p1_wdata, p2_wdata;
    logic              p0_ack,   p1_ack,   p2_ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output p0_read, p1_read, p2_read,
        output p0_write, p1_write, p2_write,
        output p0_idx, p1_idx, p2_idx,
        output p0_wdata, p1_wdata, p2_wdata,
        input  p0_ack, p1_ack, p2_ack,
        input  rdata
    );

    modport slave (
        input  p0_read, p1_read, p2_read,
        input  p0_write, p1_write, p2_write,
        input  p0_idx, p1_idx, p2_idx,
        input  p0_wdata, p1_wdata, p2_wdata,
        output p0_ack, p1_ack, p2_ack,
        output rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: search starts one past the
// last winner and wraps mod 3; returns PORT_NONE when nothing is eligible.
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] elig_i,
    input  logic [1:0] last_i,
    output logic [1:0] win_o
);

    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    assign cand0 = rr_next(last_i);
    assign cand1 = rr_next(cand0);
    assign cand2 = rr_next(cand1);

    // First eligible candidate in search order wins.
    always_comb begin
        win_o = PORT_NONE;
        if (elig_i[cand0]) begin
            win_o = cand0;
        end else if (elig_i[cand1]) begin
            win_o = cand1;
        end else if (elig_i[cand2]) begin
            win_o = cand2;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port synchronous RAM arbiter for display, CPU and GPU requesters.
// Define MEM_ARB_DISPLAY_PRIO_EN to give the display port fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        grant_port
);

    inflight_t infl_q;
    inflight_t infl_d;
    logic [1:0] rr_last_q;
    logic [1:0] rr_last_d;

    logic [2:0] req;
    logic [2:0] ack;
    logic [2:0] elig;
    logic [1:0] win;
    logic       grant_v;

    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req = {bus.p2_read | bus.p2_write,
                  bus.p1_read | bus.p1_write,
                  bus.p0_read | bus.p0_write};

    // Ack is suppressed while reset is high so an interrupted access vanishes.
    assign ack = (infl_q.valid && !reset) ? (3'b001 << infl_q.port) : 3'b000;

    // A port in its ack cycle is still showing the finished request.
    assign elig = req & ~ack;

`ifdef MEM_ARB_DISPLAY_PRIO_EN
    logic [1:0] win_disp;
    logic [1:0] win_rr;

    rr_pick3 u_disp (
        .elig_i (elig & 3'b001),
        .last_i (PORT_GPU),
        .win_o  (win_disp)
    );

    rr_pick3 u_rr (
        .elig_i (elig & 3'b110),
        .last_i (rr_last_q),
        .win_o  (win_rr)
    );

    assign win = (win_disp != PORT_NONE) ? win_disp : win_rr;
`else
    rr_pick3 u_rr (
        .elig_i (elig),
        .last_i (rr_last_q),
        .win_o  (win)
    );
`endif

    assign grant_v = (win != PORT_NONE) && !reset;

    // Route the winner's command fields toward the RAM.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (win)
            PORT_DISPLAY: begin
                sel_wr    = bus.p0_write;
                sel_addr  = bus.p0_idx;
                sel_wdata = bus.p0_wdata;
            end
            PORT_CPU: begin
                sel_wr    = bus.p1_write;
                sel_addr  = bus.p1_idx;
                sel_wdata = bus.p1_wdata;
            end
            PORT_GPU: begin
                sel_wr    = bus.p2_write;
                sel_addr  = bus.p2_idx;
                sel_wdata = bus.p2_wdata;
            end
            default: begin
                sel_wr    = 1'b0;
            end
        endcase
    end

    assign ram_en     = grant_v;
    assign ram_we     = grant_v & sel_wr;
    assign ram_addr   = grant_v ? sel_addr : '0;
    assign ram_wdata  = (grant_v && sel_wr) ? sel_wdata : '0;
    assign grant_port = grant_v ? win : PORT_NONE;

    assign bus.p0_ack = ack[0];
    assign bus.p1_ack = ack[1];
    assign bus.p2_ack = ack[2];
    assign bus.rdata  = ram_rdata;

    // Next in-flight record and round-robin pointer from this cycle's grant.
    always_comb begin
        infl_d       = '0;
        rr_last_d    = rr_last_q;
        infl_d.valid = grant_v;
        if (grant_v) begin
            infl_d.port = win;
`ifdef MEM_ARB_DISPLAY_PRIO_EN
            if (win != PORT_DISPLAY) begin
                rr_last_d = win;
            end
`else
            rr_last_d = win;
`endif
        end
    end

    // Register the in-flight access and pointer; reset favours port 0 first.
    always_ff @(posedge clk) begin
        if (reset) begin
            infl_q    <= '0;
            rr_last_q <= PORT_GPU;
        end else begin
            infl_q    <= infl_d;
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a behavioural
// synchronous-read RAM; prio-mode steps run when MEM_ARB_DISPLAY_PRIO_EN is set.
`timescale 1ns/100ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic [1:0] port;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [1:0]  grant_port;

    logic [2:0]  rd, wr;
    logic [11:0] idx [3];
    logic [7:0]  wd [3];
    logic [2:0]  ack_v;
    logic [2:0]  auto_drop;
    bit          sb_en;

    logic [7:0]  mem [0:4095];
    exp_t        sbq [$];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    assign bus.p0_read  = rd[0];
    assign bus.p1_read  = rd[1];
    assign bus.p2_read  = rd[2];
    assign bus.p0_write = wr[0];
    assign bus.p1_write = wr[1];
    assign bus.p2_write = wr[2];
    assign bus.p0_idx   = idx[0];
    assign bus.p1_idx   = idx[1];
    assign bus.p2_idx   = idx[2];
    assign bus.p0_wdata = wd[0];
    assign bus.p1_wdata = wd[1];
    assign bus.p2_wdata = wd[2];
    assign ack_v = {bus.p2_ack, bus.p1_ack, bus.p0_ack};

    mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .grant_port (grant_port)
    );

    // Behavioural RAM: registered read, preloaded while reset is held.
    always @(posedge clk) begin
        if (reset) begin
            mem[12'h200] <= 8'hA5;
            mem[12'h010] <= 8'h11;
            mem[12'h020] <= 8'h22;
            mem[12'h030] <= 8'h33;
            ram_rdata    <= 8'h00;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_rd(input int p, input logic [7:0] d);
        exp_t e;
        e.port = p[1:0];
        e.rd   = 1'b1;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic exp_wr(input int p);
        exp_t e;
        e.port = p[1:0];
        e.rd   = 1'b0;
        e.data = 8'h00;
        sbq.push_back(e);
    endtask

    task automatic mon();
        exp_t e;
        if (ack_v != 3'b000) begin
            chk("ack_onehot", 32'($countones(ack_v) == 1), 32'd1);
        end
        for (int n = 0; n < 3; n++) begin
            if (ack_v[n] && sb_en) begin
                chk($sformatf("ack_p%0d_expected", n),
                    32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("ack_port", 32'(n), 32'(e.port));
                    if (e.rd) chk("rdata", 32'(bus.rdata), 32'(e.data));
                end
            end
        end
    endtask

    // Advance to 1 unit past the edge, score acks, drop acked requests,
    // and return at the input drive point 2 units past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        mon();
        for (int n = 0; n < 3; n++) begin
            if (ack_v[n] && auto_drop[n]) begin
                rd[n] = 1'b0;
                wr[n] = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [7:0]  dat3 [3];
        logic [11:0] gaddr [3];
        int          last_g [3];
        int          g;
        dat3  = '{8'h11, 8'h22, 8'h33};
        gaddr = '{12'h010, 12'h020, 12'h030};
        rd = 3'b000;
        wr = 3'b000;
        auto_drop = 3'b111;
        sb_en = 1'b1;
        for (int n = 0; n < 3; n++) begin
            idx[n] = '0;
            wd[n]  = '0;
        end
        reset = 1'b1;
        tick();
        tick();

        // Reset state, sampled with reset still asserted
        #1;
        chk("rst_ack", 32'(ack_v), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_grant", 32'(grant_port), 32'd3);
        reset = 1'b0;
        tick();

        // Single read by the CPU
        rd[1] = 1'b1;
        idx[1] = 12'h200;
        exp_rd(1, 8'hA5);
        #1;
        chk("rd_en", 32'(ram_en), 32'd1);
        chk("rd_we", 32'(ram_we), 32'd0);
        chk("rd_addr", 32'(ram_addr), 32'h200);
        chk("rd_grant", 32'(grant_port), 32'd1);
        tick();
        #1;
        chk("rd_idle_en", 32'(ram_en), 32'd0);
        chk("rd_idle_grant", 32'(grant_port), 32'd3);

        // GPU write then readback
        wr[2] = 1'b1;
        idx[2] = 12'h108;
        wd[2] = 8'h3C;
        exp_wr(2);
        #1;
        chk("wr_en", 32'(ram_en), 32'd1);
        chk("wr_we", 32'(ram_we), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'h108);
        chk("wr_wdata", 32'(ram_wdata), 32'h3C);
        chk("wr_grant", 32'(grant_port), 32'd2);
        tick();
        rd[2] = 1'b1;
        #1;
        chk("p2_no_regrant", 32'(grant_port), 32'd3);
        chk("mem_108", 32'(mem[12'h108]), 32'h3C);
        exp_rd(2, 8'h3C);
        tick();
        #1;
        chk("rb_grant", 32'(grant_port), 32'd2);
        chk("rb_we", 32'(ram_we), 32'd0);
        chk("rb_wdata", 32'(ram_wdata), 32'd0);
        tick();

        // Three-way contention with requests held high throughout
        auto_drop = 3'b000;
        idx[0] = 12'h010;
        idx[1] = 12'h020;
        idx[2] = 12'h030;
        rd = 3'b111;
        for (int k = 0; k < 6; k++) exp_rd(k % 3, dat3[k % 3]);
        last_g = '{-1, -1, -1};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 32'(grant_port), 32'(k % 3));
            chk("rr_en", 32'(ram_en), 32'd1);
            g = int'(grant_port);
            if (g < 3) begin
                if (last_g[g] >= 0)
                    chk("rr_gap", 32'((k - last_g[g]) <= 3), 32'd1);
                last_g[g] = k;
            end
            tick();
        end
        rd = 3'b000;
        auto_drop = 3'b111;
        tick();
        #1;
        chk("rr_idle_en", 32'(ram_en), 32'd0);

        // GPU back-to-back against a constantly requesting CPU
        auto_drop = 3'b101;
        rd[1] = 1'b1;
        idx[1] = 12'h200;
        rd[2] = 1'b1;
        idx[2] = gaddr[0];
        for (int k = 0; k < 3; k++) begin
            exp_rd(1, 8'hA5);
            exp_rd(2, dat3[k]);
        end
        for (int k = 0; k < 6; k++) begin
            if (k == 3 || k == 5) begin
                rd[2] = 1'b1;
                idx[2] = gaddr[k / 2];
            end
            #1;
            chk("b2b_grant", 32'(grant_port), (k % 2 == 1) ? 32'd2 : 32'd1);
            chk("b2b_no_ack_grant",
                32'(grant_port == 2'd2 && ack_v[2]), 32'd0);
            tick();
        end
        rd[1] = 1'b0;
        auto_drop = 3'b111;
        #1;
        chk("b2b_idle_en", 32'(ram_en), 32'd0);
        tick();

        // Read and write asserted together: write wins, one ack
        rd[1] = 1'b1;
        wr[1] = 1'b1;
        idx[1] = 12'h150;
        wd[1] = 8'h77;
        exp_wr(1);
        #1;
        chk("rw_we", 32'(ram_we), 32'd1);
        chk("rw_addr", 32'(ram_addr), 32'h150);
        chk("rw_wdata", 32'(ram_wdata), 32'h77);
        chk("rw_grant", 32'(grant_port), 32'd1);
        tick();
        #1;
        chk("mem_150", 32'(mem[12'h150]), 32'h77);
        chk("rw_idle_en", 32'(ram_en), 32'd0);
        tick();
        tick();

        // Reset raised inside the ack cycle of a display read
        auto_drop = 3'b110;
        rd[0] = 1'b1;
        idx[0] = 12'h010;
        #1;
        chk("mid_grant", 32'(grant_port), 32'd0);
        @(posedge clk);
        #0.5;
        reset = 1'b1;
        #0.5;
        chk("mid_ack_drop", 32'(bus.p0_ack), 32'd0);
        chk("mid_en", 32'(ram_en), 32'd0);
        chk("mid_grant_none", 32'(grant_port), 32'd3);
        #1;
        tick();
        reset = 1'b0;
        rd[1] = 1'b1;
        idx[1] = 12'h200;
        exp_rd(0, 8'h11);
        exp_rd(1, 8'hA5);
        #1;
        chk("post_rst_grant", 32'(grant_port), 32'd0);
        tick();
        rd[0] = 1'b0;
        #1;
        chk("post_rst_grant2", 32'(grant_port), 32'd1);
        tick();
        auto_drop = 3'b111;
        tick();

`ifdef MEM_ARB_DISPLAY_PRIO_EN
        // Display preempts saturating CPU/GPU traffic
        sb_en = 1'b0;
        auto_drop = 3'b001;
        rd[1] = 1'b1;
        rd[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) rd[0] = 1'b1;
            #1;
            if (k % 2 == 0) chk("prio_disp", 32'(grant_port), 32'd0);
            else chk("prio_other", 32'(grant_port != 2'd0), 32'd1);
            tick();
        end
        rd = 3'b000;
        tick();
        tick();
        sb_en = 1'b1;
        auto_drop = 3'b111;
`endif

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
